// File: rtl/psmac_pkg.sv
// ---------------------------------------------------------------------------
// psmac_pkg
// Shared types and helpers for the precision-scalable MAC sequencer.
//   state_t    : sequencer FSM states
//   MODE_*     : multiplier precision modes, passed straight to the multiplier
//   sign_mask  : per-2-bit-digit sign flags for an 8-bit operand
//   ext_prod   : widens a 16-bit product to accumulator width
// ---------------------------------------------------------------------------
package psmac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [1:0] MODE_8X8 = 2'b00;
    localparam logic [1:0] MODE_4X4 = 2'b01;
    localparam logic [1:0] MODE_2X2 = 2'b10;

    localparam int MAX_ACC_W = 48;

    // In full 8x8 mode only the most significant 2-bit digit carries the
    // operand sign; the lower digits are always magnitude bits.
    function automatic logic [3:0] sign_mask(input logic sgn);
        return {sgn, 3'b000};
    endfunction

    // Sign- or zero-extends the product to MAX_ACC_W bits, then clears
    // everything above acc_w so the caller can truncate without surprises.
    function automatic logic [MAX_ACC_W-1:0] ext_prod(input logic [15:0] y,
                                                      input logic sgn,
                                                      input int acc_w);
        logic [MAX_ACC_W-1:0] r;
        r = sgn ? {{(MAX_ACC_W-16){y[15]}}, y} : {{(MAX_ACC_W-16){1'b0}}, y};
        for (int i = 16; i < MAX_ACC_W; i++) begin
            if (i >= acc_w) begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/psmac_seq_if.sv
// ---------------------------------------------------------------------------
// psmac_seq_if
// Bundles the job-descriptor handshake, operand stream, multiplier link and
// result handshake of the MAC sequencer.
//   slave  : the sequencer's view (psmac_seq)
//   master : the parent / driver view (config source, operand source,
//            multiplier and result sink)
// ---------------------------------------------------------------------------
interface psmac_seq_if
    import psmac_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int LEN_W = 10
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_a_signed;
    logic             cfg_b_signed;
    logic [ACC_W-1:0] cfg_bias;
    logic             cfg_relu;
    logic [1:0]       cfg_mode;

    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;

    logic [7:0]       mul_mr;
    logic [7:0]       mul_md;
    logic [3:0]       mul_sx;
    logic [3:0]       mul_sy;
    logic [1:0]       mul_mode;
    logic [15:0]      mul_y;

    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;
    logic             busy;

    modport slave (
        input  cfg_valid, cfg_len, cfg_a_signed, cfg_b_signed, cfg_bias,
               cfg_relu, cfg_mode, in_valid, in_a, in_b, mul_y, out_ready,
        output cfg_ready, in_ready, mul_mr, mul_md, mul_sx, mul_sy, mul_mode,
               out_valid, out_data, out_ovf, busy
    );

    modport master (
        output cfg_valid, cfg_len, cfg_a_signed, cfg_b_signed, cfg_bias,
               cfg_relu, cfg_mode, in_valid, in_a, in_b, mul_y, out_ready,
        input  cfg_ready, in_ready, mul_mr, mul_md, mul_sx, mul_sy, mul_mode,
               out_valid, out_data, out_ovf, busy
    );

endinterface

// File: rtl/psmac_seq.sv
// ---------------------------------------------------------------------------
// psmac_seq
// Sequencer for the precision-scalable 8x8 MAC multiplier. Takes one
// dot-product job, streams operand pairs into the (external, combinational)
// multiplier, accumulates the products onto a bias, applies optional ReLU
// and hands out one result.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : psmac_seq_if.slave (config, operands, multiplier, result)
// ---------------------------------------------------------------------------
module psmac_seq
    import psmac_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int LEN_W = 10
) (
    input logic        clk,
    input logic        rst_n,
    psmac_seq_if.slave bus
);

    state_t           r_state;
    logic [LEN_W-1:0] r_count;
    logic             r_pipeValid;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic             r_aSigned;
    logic             r_bSigned;
    logic             r_relu;
    logic [7:0]       r_mr;
    logic [7:0]       r_md;
    logic [3:0]       r_sx;
    logic [3:0]       r_sy;
    logic [1:0]       r_mode;
    logic             r_outValid;
    logic [ACC_W-1:0] r_outData;

    logic             w_inReady;
    logic             w_accept;
    logic [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0] w_sum;
    logic             w_sumOvf;
    logic [ACC_W-1:0] w_reluAcc;

    // Operands are only taken while pairs remain; the accept that empties the
    // counter also leaves RUN, so in_ready drops on the following cycle.
    assign w_inReady = (r_state == RUN) && (r_count != '0);
    assign w_accept  = bus.in_valid && w_inReady;

    // The product belongs to the pair registered one cycle earlier. Signed
    // overflow shows up as two same-signed addends giving an opposite sign.
    assign w_ext     = ACC_W'(ext_prod(bus.mul_y, r_aSigned | r_bSigned, ACC_W));
    assign w_sum     = r_acc + w_ext;
    assign w_sumOvf  = (r_acc[ACC_W-1] == w_ext[ACC_W-1]) &&
                       (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
    assign w_reluAcc = (r_relu && r_acc[ACC_W-1]) ? '0 : r_acc;

    assign bus.cfg_ready = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.in_ready  = w_inReady;
    assign bus.mul_mr    = r_mr;
    assign bus.mul_md    = r_md;
    assign bus.mul_sx    = r_sx;
    assign bus.mul_sy    = r_sy;
    assign bus.mul_mode  = r_mode;
    assign bus.out_valid = r_outValid;
    assign bus.out_data  = r_outData;
    assign bus.out_ovf   = r_ovf;

    // Whole sequencer: accumulate stage runs in every state whenever a
    // product is in flight; the FSM below it owns descriptor latching,
    // operand streaming, drain and the result handshake. A reset abandons
    // any job in progress without producing a result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_pipeValid <= 1'b0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_aSigned   <= 1'b0;
            r_bSigned   <= 1'b0;
            r_relu      <= 1'b0;
            r_mr        <= '0;
            r_md        <= '0;
            r_sx        <= '0;
            r_sy        <= '0;
            r_mode      <= MODE_8X8;
            r_outValid  <= 1'b0;
            r_outData   <= '0;
        end else begin
            if (r_pipeValid) begin
                r_acc <= w_sum;
                if (w_sumOvf) begin
                    r_ovf <= 1'b1;
                end
            end

            r_pipeValid <= w_accept;
            if (w_accept) begin
                r_mr <= bus.in_a;
                r_md <= bus.in_b;
            end

            case (r_state)
                IDLE: begin
                    if (bus.cfg_valid) begin
                        r_count   <= bus.cfg_len;
                        r_aSigned <= bus.cfg_a_signed;
                        r_bSigned <= bus.cfg_b_signed;
                        r_relu    <= bus.cfg_relu;
                        r_mode    <= bus.cfg_mode;
                        r_sx      <= sign_mask(bus.cfg_a_signed);
                        r_sy      <= sign_mask(bus.cfg_b_signed);
                        r_acc     <= bus.cfg_bias;
                        r_ovf     <= 1'b0;
                        r_state   <= (bus.cfg_len != '0) ? RUN : OUT;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_count <= r_count - LEN_W'(1);
                        if (r_count == LEN_W'(1)) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!r_pipeValid) begin
                        r_outData  <= w_reluAcc;
                        r_outValid <= 1'b1;
                        r_state    <= OUT;
                    end
                end
                OUT: begin
                    // An empty job arrives here straight from IDLE with no
                    // result loaded yet, so it is formed on the first cycle.
                    if (!r_outValid) begin
                        r_outData  <= w_reluAcc;
                        r_outValid <= 1'b1;
                    end else if (bus.out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psmac_seq.sv
// ---------------------------------------------------------------------------
// tb_psmac_seq
// Self-checking bench for psmac_seq. Two instances (ACC_W=32 and ACC_W=18)
// see identical stimulus; a behavioural multiplier closes the mul_* loop and
// a scoreboard holds the expected result of every job for both widths.
// ---------------------------------------------------------------------------
module tb_psmac_seq;
    import psmac_pkg::*;

    typedef struct {
        logic [31:0] data32;
        logic        ovf32;
        logic [17:0] data18;
        logic        ovf18;
    } expect_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        cfgValid = 1'b0;
    logic [9:0]  cfgLen = '0;
    logic        cfgASigned = 1'b0;
    logic        cfgBSigned = 1'b0;
    logic [31:0] cfgBias = '0;
    logic        cfgRelu = 1'b0;
    logic [1:0]  cfgMode = '0;
    logic        inValid = 1'b0;
    logic [7:0]  inA = '0;
    logic [7:0]  inB = '0;
    logic        outReady = 1'b1;

    logic [7:0]  jobA [0:15];
    logic [7:0]  jobB [0:15];
    expect_t     sb [$];

    int checks = 0;
    int passed = 0;

    psmac_seq_if #(.ACC_W(32), .LEN_W(10)) bus32 ();
    psmac_seq_if #(.ACC_W(18), .LEN_W(10)) bus18 ();

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    // Behavioural stand-in for the 8x8 multiplier: the top sign flag selects
    // two's complement or unsigned interpretation of each operand.
    function automatic logic [15:0] mulModel(input logic [7:0] mr, input logic [7:0] md,
                                             input logic [3:0] sx, input logic [3:0] sy);
        logic signed [31:0] a;
        logic signed [31:0] b;
        logic signed [31:0] p;
        a = sx[3] ? {{24{mr[7]}}, mr} : {24'b0, mr};
        b = sy[3] ? {{24{md[7]}}, md} : {24'b0, md};
        p = a * b;
        return p[15:0];
    endfunction

    // Shared stimulus fan-out to both widths.
    assign bus32.cfg_valid    = cfgValid;
    assign bus32.cfg_len      = cfgLen;
    assign bus32.cfg_a_signed = cfgASigned;
    assign bus32.cfg_b_signed = cfgBSigned;
    assign bus32.cfg_bias     = cfgBias;
    assign bus32.cfg_relu     = cfgRelu;
    assign bus32.cfg_mode     = cfgMode;
    assign bus32.in_valid     = inValid;
    assign bus32.in_a         = inA;
    assign bus32.in_b         = inB;
    assign bus32.out_ready    = outReady;
    assign bus32.mul_y        = mulModel(bus32.mul_mr, bus32.mul_md, bus32.mul_sx, bus32.mul_sy);

    assign bus18.cfg_valid    = cfgValid;
    assign bus18.cfg_len      = cfgLen;
    assign bus18.cfg_a_signed = cfgASigned;
    assign bus18.cfg_b_signed = cfgBSigned;
    assign bus18.cfg_bias     = cfgBias[17:0];
    assign bus18.cfg_relu     = cfgRelu;
    assign bus18.cfg_mode     = cfgMode;
    assign bus18.in_valid     = inValid;
    assign bus18.in_a         = inA;
    assign bus18.in_b         = inB;
    assign bus18.out_ready    = outReady;
    assign bus18.mul_y        = mulModel(bus18.mul_mr, bus18.mul_md, bus18.mul_sx, bus18.mul_sy);

    psmac_seq #(.ACC_W(32), .LEN_W(10)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    psmac_seq #(.ACC_W(18), .LEN_W(10)) dut18 (.clk(clk), .rst_n(rst_n), .bus(bus18));

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Keeps the low w bits of v, sign-extended back to 64 bits.
    function automatic logic signed [63:0] wrapW(input logic signed [63:0] v, input int w);
        logic signed [63:0] t;
        t = v <<< (64 - w);
        return t >>> (64 - w);
    endfunction

    // Reference result for the job currently described in cfg*/jobA/jobB,
    // modelled at 32 and 18 bits with exact overflow detection.
    function automatic expect_t computeExpect(input int len, input logic aS, input logic bS,
                                              input logic [31:0] bias, input logic relu);
        expect_t e;
        logic signed [63:0] acc32;
        logic signed [63:0] acc18;
        logic signed [63:0] p;
        logic signed [63:0] s;
        logic [15:0] y;
        e.ovf32 = 1'b0;
        e.ovf18 = 1'b0;
        acc32 = {{32{bias[31]}}, bias};
        acc18 = wrapW(acc32, 18);
        for (int i = 0; i < len; i++) begin
            y = mulModel(jobA[i], jobB[i], {aS, 3'b000}, {bS, 3'b000});
            p = (aS | bS) ? {{48{y[15]}}, y} : {48'b0, y};
            s = acc32 + p;
            if (wrapW(s, 32) != s) e.ovf32 = 1'b1;
            acc32 = wrapW(s, 32);
            s = acc18 + p;
            if (wrapW(s, 18) != s) e.ovf18 = 1'b1;
            acc18 = wrapW(s, 18);
        end
        e.data32 = (relu && acc32 < 0) ? 32'd0 : acc32[31:0];
        e.data18 = (relu && acc18 < 0) ? 18'd0 : acc18[17:0];
        return e;
    endfunction

    // Everything a reset must clear, on both instances.
    task automatic checkReset(input string tag);
        checkOutput({tag, "CfgReady"}, {bus32.cfg_ready, bus18.cfg_ready}, 2'b11);
        checkOutput({tag, "Outputs"},
                    {bus32.in_ready, bus32.busy, bus32.out_valid, bus32.out_ovf,
                     bus32.mul_mode, bus32.mul_sx, bus32.mul_sy, bus32.mul_mr, bus32.mul_md,
                     bus18.in_ready, bus18.busy, bus18.out_valid, bus18.out_ovf}, '0);
        checkOutput({tag, "OutData"}, {bus18.out_data, bus32.out_data}, '0);
    endtask

    // Drives one job: descriptor, operand stream (from jobA/jobB), optional
    // output backpressure for holdCycles, or a reset after abortAfter accepts.
    task automatic applyStimulus(input int len, input logic aS, input logic bS,
                                 input logic [31:0] bias, input logic relu,
                                 input logic [1:0] mode, input int holdCycles,
                                 input int abortAfter);
        int n;
        logic sawIn;
        n = 0;
        while (!bus32.cfg_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        checkOutput("cfgReadyWait", bus32.cfg_ready, 1);
        cfgLen     = 10'(len);
        cfgASigned = aS;
        cfgBSigned = bS;
        cfgBias    = bias;
        cfgRelu    = relu;
        cfgMode    = mode;
        outReady   = (holdCycles == 0);
        cfgValid   = 1'b1;
        @(posedge clk); #1;
        cfgValid   = 1'b0;
        checkOutput("mulMode", bus32.mul_mode, mode);
        checkOutput("signMasks", {bus32.mul_sx, bus32.mul_sy}, {aS, 3'b000, bS, 3'b000});
        if (abortAfter < 0) sb.push_back(computeExpect(len, aS, bS, bias, relu));

        if (len == 0) begin
            n = 1;
            sawIn = 1'b0;
            while (!bus32.out_valid && n < 10) begin
                if (bus32.in_ready) sawIn = 1'b1;
                @(posedge clk); #1; n++;
            end
            checkOutput("emptyLatency", n, 2);
            checkOutput("emptyInReady", sawIn, 0);
        end else begin
            for (int i = 0; i < len; i++) begin
                inA = jobA[i];
                inB = jobB[i];
                inValid = 1'b1;
                n = 0;
                while (!bus32.in_ready && n < 20) begin
                    @(posedge clk); #1; n++;
                end
                if (!bus32.in_ready) begin
                    checkOutput("inReadyWait", 0, 1);
                    break;
                end
                @(posedge clk); #1;
                if (abortAfter == i + 1) begin
                    inValid = 1'b0;
                    rst_n = 1'b0;
                    #1;
                    checkReset("abort");
                    #2;
                    rst_n = 1'b1;
                    return;
                end
                if (i == 1 && len > 2) begin
                    inValid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            inValid = 1'b0;
            checkOutput("inReadyDrop", bus32.in_ready, 0);
            n = 0;
            while (!bus32.out_valid && n < 10) begin
                @(posedge clk); #1; n++;
            end
            checkOutput("latency", n, 2);
        end

        if (holdCycles > 0) begin
            for (int h = 0; h < holdCycles; h++) begin
                @(posedge clk); #1;
                checkOutput("holdData32", bus32.out_data, sb[0].data32);
                checkOutput("holdData18", bus18.out_data, sb[0].data18);
                checkOutput("holdFlags", {bus32.out_valid, bus32.cfg_ready}, 2'b10);
            end
            outReady = 1'b1;
        end

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        checkOutput("scoreboardEmpty", sb.size(), 0);
    endtask

    // Result collector: sampled on the falling edge while a handshake is
    // pending, popping one expected entry per delivered result.
    always @(negedge clk) begin
        if (rst_n && bus32.out_valid && outReady) begin
            if (sb.size() == 0) begin
                checkOutput("unexpectedOutput", 1, 0);
            end else begin
                expect_t e;
                e = sb.pop_front();
                checkOutput("data32", bus32.out_data, e.data32);
                checkOutput("ovf32", bus32.out_ovf, e.ovf32);
                checkOutput("valid18", bus18.out_valid, 1);
                checkOutput("data18", bus18.out_data, e.data18);
                checkOutput("ovf18", bus18.out_ovf, e.ovf18);
            end
        end
    end

    // Main sequence of directed jobs followed by one random job.
    initial begin
        #2;
        checkReset("initial");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Unsigned 255*255 x3: fits 32 bits, overflows and wraps at 18 bits;
        // result held under backpressure for 5 cycles.
        for (int i = 0; i < 3; i++) begin jobA[i] = 8'd255; jobB[i] = 8'd255; end
        applyStimulus(3, 1'b0, 1'b0, 32'd0, 1'b0, MODE_8X8, 5, -1);
        checkOutput("spotUnsigned18", {bus18.out_ovf, bus18.out_data}, {1'b1, 18'h2FA03});

        // Signed with bias.
        jobA[0] = 8'h80; jobB[0] = 8'h80;
        jobA[1] = 8'hFF; jobB[1] = 8'h7F;
        applyStimulus(2, 1'b1, 1'b1, 32'd10, 1'b0, MODE_8X8, 0, -1);
        checkOutput("spotSigned", bus32.out_data, 32'd16267);

        // Negative result with and without ReLU.
        jobA[0] = 8'hFB; jobB[0] = 8'd7;
        applyStimulus(1, 1'b1, 1'b1, 32'd0, 1'b1, MODE_8X8, 0, -1);
        checkOutput("spotRelu", bus32.out_data, 32'd0);
        applyStimulus(1, 1'b1, 1'b1, 32'd0, 1'b0, MODE_8X8, 0, -1);
        checkOutput("spotNoRelu", bus32.out_data, 32'hFFFFFFDD);

        // Mixed signedness, negative bias, non-default mode.
        jobA[0] = 8'hFF; jobB[0] = 8'd255;
        jobA[1] = 8'd100; jobB[1] = 8'd200;
        applyStimulus(2, 1'b1, 1'b0, -32'sd100, 1'b0, MODE_4X4, 0, -1);

        // Empty jobs: bias passes through, with ReLU on a negative bias.
        applyStimulus(0, 1'b0, 1'b0, 32'd42, 1'b0, MODE_2X2, 0, -1);
        checkOutput("spotEmpty", bus32.out_data, 32'd42);
        applyStimulus(0, 1'b1, 1'b0, -32'sd7, 1'b1, MODE_8X8, 0, -1);

        // Reset after 2 of 4 accepts, then a fresh job.
        for (int i = 0; i < 4; i++) begin jobA[i] = 8'd9; jobB[i] = 8'd9; end
        applyStimulus(4, 1'b0, 1'b0, 32'd5, 1'b0, MODE_8X8, 0, 2);
        jobA[0] = 8'd3; jobB[0] = 8'd4;
        applyStimulus(1, 1'b0, 1'b0, 32'd0, 1'b0, MODE_8X8, 0, -1);
        checkOutput("spotAfterReset", bus32.out_data, 32'd12);

        // Random job.
        for (int i = 0; i < 8; i++) begin
            jobA[i] = 8'($urandom);
            jobB[i] = 8'($urandom);
        end
        applyStimulus(8, 1'($urandom), 1'($urandom), $urandom, 1'($urandom), MODE_8X8, 0, -1);

        repeat (3) @(posedge clk);
        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
